// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter
//   Multi-digit BCD up/down counter with enable, synchronous parallel load
//   (non-BCD digits are clamped to 9), and wrap or saturate at the limits.
//   tc is a combinational terminal count so instances can be cascaded: drive
//   the downstream en from the upstream tc.
//
// Parameters
//   DIGITS   number of BCD digits (1..8), count width = 4*DIGITS
//   WRAP     1 = wrap at limits, 0 = saturate at limits
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   en        count enable
//   up        1 = increment, 0 = decrement
//   load      synchronous load, priority over en
//   load_val  BCD load value, digit 0 in [3:0]
//   count     registered BCD count
//   tc        combinational terminal count
//   ovf       one-cycle pulse on wrap/saturation attempt
//   load_err  one-cycle pulse when a loaded digit was > 9
module bcd_updown_counter #(
    parameter int DIGITS = 4,
    parameter bit WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  ovf,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0]      count_reg;
    logic [W-1:0]      count_next;
    logic              ovf_reg;
    logic              ovf_next;
    logic              load_err_reg;
    logic              load_err_next;

    logic [W-1:0]      inc_val;
    logic [W-1:0]      dec_val;
    logic [W-1:0]      load_fix;
    logic [DIGITS:0]   carry;
    logic [DIGITS:0]   borrow;
    logic [DIGITS-1:0] dig_nine;
    logic [DIGITS-1:0] dig_zero;
    logic [DIGITS-1:0] dig_bad;

    logic              all_nine;
    logic              all_zero;
    logic              at_limit;

    // Digit 0 always steps; higher digits step only when every lower digit
    // rolled over, so the carry/borrow ripples within one cycle.
    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi = gi + 1) begin : g_digit
            logic [3:0] d;
            logic [3:0] lv;

            assign d  = count_reg[4*gi +: 4];
            assign lv = load_val[4*gi +: 4];

            assign dig_nine[gi] = (d == 4'd9);
            assign dig_zero[gi] = (d == 4'd0);

            assign inc_val[4*gi +: 4] = carry[gi]
                                      ? (dig_nine[gi] ? 4'd0 : d + 4'd1)
                                      : d;
            assign dec_val[4*gi +: 4] = borrow[gi]
                                      ? (dig_zero[gi] ? 4'd9 : d - 4'd1)
                                      : d;

            assign carry[gi+1]  = carry[gi]  & dig_nine[gi];
            assign borrow[gi+1] = borrow[gi] & dig_zero[gi];

            // Clamp invalid digits so count can never hold a non-BCD value.
            assign dig_bad[gi]         = (lv > 4'd9);
            assign load_fix[4*gi +: 4] = dig_bad[gi] ? 4'd9 : lv;
        end
    endgenerate

    assign all_nine = &dig_nine;
    assign all_zero = &dig_zero;
    assign at_limit = up ? all_nine : all_zero;

    always_comb begin
        count_next    = count_reg;
        ovf_next      = 1'b0;
        load_err_next = 1'b0;
        if (load) begin
            count_next    = load_fix;
            load_err_next = |dig_bad;
        end else if (en) begin
            ovf_next = at_limit;
            // Plain increment/decrement already wraps 9..9 <-> 0..0, so only
            // the saturating build needs to suppress the step at the limit.
            if (at_limit && (WRAP == 1'b0)) begin
                count_next = count_reg;
            end else begin
                count_next = up ? inc_val : dec_val;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg    <= '0;
            ovf_reg      <= 1'b0;
            load_err_reg <= 1'b0;
        end else begin
            count_reg    <= count_next;
            ovf_reg      <= ovf_next;
            load_err_reg <= load_err_next;
        end
    end

    assign count    = count_reg;
    assign ovf      = ovf_reg;
    assign load_err = load_err_reg;
    assign tc       = en & ~load & at_limit;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed testbench for bcd_updown_counter: a wrapping and a saturating
// 4-digit instance share stimulus; two 2-digit wrapping instances form a
// cascade through tc.
module tb_bcd_updown_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        up;
    logic        load;
    logic [15:0] load_val;

    logic [15:0] count_w, count_s;
    logic        tc_w, tc_s, ovf_w, ovf_s, err_w, err_s;

    logic        c_en, c_load;
    logic [7:0]  c_lv_lo, c_lv_hi;
    logic [7:0]  c_cnt_lo, c_cnt_hi;
    logic        c_tc_lo, c_tc_hi, c_ovf_lo, c_ovf_hi, c_err_lo, c_err_hi;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bcd_updown_counter #(.DIGITS(4), .WRAP(1'b1)) dut_w (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count_w), .tc(tc_w), .ovf(ovf_w),
        .load_err(err_w)
    );

    bcd_updown_counter #(.DIGITS(4), .WRAP(1'b0)) dut_s (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count_s), .tc(tc_s), .ovf(ovf_s),
        .load_err(err_s)
    );

    bcd_updown_counter #(.DIGITS(2), .WRAP(1'b1)) dut_lo (
        .clk(clk), .reset(reset), .en(c_en), .up(up), .load(c_load),
        .load_val(c_lv_lo), .count(c_cnt_lo), .tc(c_tc_lo), .ovf(c_ovf_lo),
        .load_err(c_err_lo)
    );

    bcd_updown_counter #(.DIGITS(2), .WRAP(1'b1)) dut_hi (
        .clk(clk), .reset(reset), .en(c_tc_lo), .up(up), .load(c_load),
        .load_val(c_lv_hi), .count(c_cnt_hi), .tc(c_tc_hi), .ovf(c_ovf_hi),
        .load_err(c_err_hi)
    );

    task automatic check_vec(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        en       = 1'b1;
        up       = 1'b1;
        load     = 1'b0;
        load_val = 16'h0000;
        c_en     = 1'b0;
        c_load   = 1'b0;
        c_lv_lo  = 8'h00;
        c_lv_hi  = 8'h00;

        // Reset held with en high
        repeat (5) tick();
        check_vec("rst_count", {16'h0, count_w}, 32'h0000);
        check_vec("rst_ovf", {31'h0, ovf_w}, 32'h0);
        check_vec("rst_err", {31'h0, err_w}, 32'h0);

        en    = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        check_vec("hold_after_rst", {16'h0, count_w}, 32'h0000);

        // Decimal carry
        load = 1'b1; load_val = 16'h0998;
        tick();
        check_vec("load_0998", {16'h0, count_w}, 32'h0998);
        check_vec("load_0998_ovf", {31'h0, ovf_w}, 32'h0);
        load = 1'b0; en = 1'b1; up = 1'b1;
        tick(); check_vec("up_0999", {16'h0, count_w}, 32'h0999);
        tick(); check_vec("up_1000", {16'h0, count_w}, 32'h1000);
        tick(); check_vec("up_1001", {16'h0, count_w}, 32'h1001);

        en = 1'b0; load = 1'b1; load_val = 16'h1000;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b0;
        tick(); check_vec("dn_0999", {16'h0, count_w}, 32'h0999);

        // Upper limit: wrap and saturate side by side
        en = 1'b0; load = 1'b1; load_val = 16'h9999;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        #1;
        check_vec("tc_w_before_wrap", {31'h0, tc_w}, 32'h1);
        check_vec("tc_s_before_sat", {31'h0, tc_s}, 32'h1);
        tick();
        check_vec("wrap_up_count", {16'h0, count_w}, 32'h0000);
        check_vec("wrap_up_ovf", {31'h0, ovf_w}, 32'h1);
        check_vec("sat_up1_count", {16'h0, count_s}, 32'h9999);
        check_vec("sat_up1_ovf", {31'h0, ovf_s}, 32'h1);
        tick();
        check_vec("wrap_next_count", {16'h0, count_w}, 32'h0001);
        check_vec("wrap_ovf_cleared", {31'h0, ovf_w}, 32'h0);
        check_vec("sat_up2_count", {16'h0, count_s}, 32'h9999);
        check_vec("sat_up2_ovf", {31'h0, ovf_s}, 32'h1);
        tick();
        check_vec("sat_up3_count", {16'h0, count_s}, 32'h9999);
        check_vec("sat_up3_ovf", {31'h0, ovf_s}, 32'h1);
        en = 1'b0;
        tick();
        check_vec("sat_ovf_cleared", {31'h0, ovf_s}, 32'h0);

        // Lower limit
        load = 1'b1; load_val = 16'h0000;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b0;
        tick();
        check_vec("wrap_dn_count", {16'h0, count_w}, 32'h9999);
        check_vec("wrap_dn_ovf", {31'h0, ovf_w}, 32'h1);
        check_vec("sat_dn_count", {16'h0, count_s}, 32'h0000);
        check_vec("sat_dn_ovf", {31'h0, ovf_s}, 32'h1);
        en = 1'b0;

        // Load validation
        load = 1'b1; load_val = 16'h3A7F;
        tick();
        check_vec("load_clamp", {16'h0, count_w}, 32'h3979);
        check_vec("load_err_set", {31'h0, err_w}, 32'h1);
        load = 1'b0;
        tick();
        check_vec("load_err_clear", {31'h0, err_w}, 32'h0);
        check_vec("hold_3979", {16'h0, count_w}, 32'h3979);

        // Load has priority over en
        load = 1'b1; en = 1'b1; up = 1'b1; load_val = 16'h0042;
        #1;
        check_vec("tc_blocked_by_load", {31'h0, tc_w}, 32'h0);
        tick();
        check_vec("load_prio_count", {16'h0, count_w}, 32'h0042);
        check_vec("load_prio_ovf", {31'h0, ovf_w}, 32'h0);
        load = 1'b0; en = 1'b0;

        // Cascade of two 2-digit counters
        c_load = 1'b1; c_lv_lo = 8'h99; c_lv_hi = 8'h05;
        tick();
        c_load = 1'b0; c_en = 1'b1; up = 1'b1;
        #1;
        check_vec("cascade_tc_lo", {31'h0, c_tc_lo}, 32'h1);
        tick();
        check_vec("cascade_count", {16'h0, c_cnt_hi, c_cnt_lo}, 32'h0600);
        check_vec("cascade_hi_ovf", {31'h0, c_ovf_hi}, 32'h0);
        c_en = 1'b0;

        // Asynchronous reset between edges
        load = 1'b1; load_val = 16'h1234;
        tick();
        load = 1'b0;
        check_vec("pre_async_count", {16'h0, count_w}, 32'h1234);
        #2 reset = 1'b0;
        #1;
        check_vec("async_rst_count", {16'h0, count_w}, 32'h0000);
        check_vec("async_rst_tc", {31'h0, tc_w}, 32'h0);
        reset = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
